// File: rtl/dbg_jtag_vpi_pkg.sv
// Shared types and constants for the dbg_jtag_vpi JTAG master.
package dbg_jtag_vpi_pkg;

    localparam int unsigned TAP_RESET_LEN = 5;
    localparam int unsigned MAX_LEN       = 32;

    typedef enum logic [1:0] {
        OpTapReset = 2'd0,
        OpTmsSeq   = 2'd1,
        OpScan     = 2'd2,
        OpScanExit = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        StWaitInit,
        StIdle,
        StLo,
        StHi,
        StDone
    } state_e;

    // Pin values {tms, tdi} for one shifted bit of a command.
    function automatic logic [1:0] bit_pins(op_e op, logic data_bit, logic last_bit);
        logic [1:0] pins;
        unique case (op)
            OpTapReset: pins = 2'b10;
            OpTmsSeq:   pins = {data_bit, 1'b0};
            OpScan:     pins = {1'b0, data_bit};
            OpScanExit: pins = {last_bit, data_bit};
        endcase
        return pins;
    endfunction

endpackage

// File: rtl/dbg_jtag_vpi_tck_gen.sv
// TCK phase timer: counts TCK_DIV cycles per LO/HI phase and flags the
// first and last cycle of the current phase.
module dbg_jtag_vpi_tck_gen #(
    parameter int unsigned TCK_DIV = 2
) (
    input  logic wb_clk_i,
    input  logic wb_rst_ni,
    input  logic run_i,
    output logic phase_first_o,
    output logic phase_end_o
);

    localparam logic [7:0] LastCnt = 8'(TCK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    assign phase_first_o = run_i && (cnt_q == 8'd0);
    assign phase_end_o   = run_i && (cnt_q == LastCnt);

    // Restart at every phase boundary; hold at zero while not shifting.
    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (!run_i || phase_end_o) begin
            cnt_d = 8'd0;
        end
    end

    // Phase counter register.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dbg_jtag_vpi.sv
// dbg_jtag_vpi: command-driven JTAG master. Each accepted command shifts
// up to 32 bits over tck/tms/tdi, captures tdo, and pulses rsp_valid.
// Optional: define DBG_JTAG_VPI_TCK_COUNT_EN to add the tck_count output.
module dbg_jtag_vpi
    import dbg_jtag_vpi_pkg::*;
#(
    parameter int unsigned TCK_DIV = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        enable,
    input  logic        init_done,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
`ifdef DBG_JTAG_VPI_TCK_COUNT_EN
    ,
    output logic [31:0] tck_count
`endif
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [31:0] data_q, data_d;
    logic [5:0]  len_q, len_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] cap_q, cap_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;
    logic        phase_first, phase_end;
    logic        shifting, last_bit, accept;
    op_e         cmd_op_e;

    assign cmd_op_e  = op_e'(cmd_op);
    assign shifting  = (state_q == StLo) || (state_q == StHi);
    assign last_bit  = ({1'b0, idx_q} == (len_q - 6'd1));
    assign cmd_ready = enable && (state_q == StIdle);
    assign accept    = cmd_valid && cmd_ready;

    // Pins go idle combinationally as soon as enable drops.
    assign tck       = enable && (state_q == StHi);
    assign tms       = (enable && shifting) ? tms_q : 1'b1;
    assign tdi       = (enable && shifting) ? tdi_q : 1'b0;
    assign rsp_valid = enable && (state_q == StDone);
    assign rsp_data  = rsp_data_q;

    dbg_jtag_vpi_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_ni     (wb_rst_ni),
        .run_i         (shifting),
        .phase_first_o (phase_first),
        .phase_end_o   (phase_end)
    );

    // Next-state, command load, per-bit pin update and tdo capture.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        len_d      = len_q;
        idx_d      = idx_q;
        cap_d      = cap_q;
        rsp_data_d = rsp_data_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;

        case (state_q)
            StWaitInit: begin
                if (init_done) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (accept) begin
                    state_d = StLo;
                    op_d    = cmd_op_e;
                    idx_d   = 5'd0;
                    cap_d   = 32'd0;
                    if (cmd_op_e == OpTapReset) begin
                        data_d = 32'd0;
                        len_d  = 6'(TAP_RESET_LEN);
                    end else begin
                        data_d = cmd_data;
                        len_d  = (cmd_len == 5'd0) ? 6'(MAX_LEN) : {1'b0, cmd_len};
                    end
                    {tms_d, tdi_d} = bit_pins(cmd_op_e, cmd_data[0], len_d == 6'd1);
                end
            end
            StLo: begin
                if (phase_end) begin
                    state_d = StHi;
                end
            end
            StHi: begin
                if (phase_first) begin
                    cap_d[idx_q] = tdo;
                end
                if (phase_end) begin
                    if (last_bit) begin
                        state_d    = StDone;
                        rsp_data_d = cap_d;
                    end else begin
                        state_d        = StLo;
                        idx_d          = idx_q + 5'd1;
                        {tms_d, tdi_d} = bit_pins(op_q, data_q[idx_d],
                                                  {1'b0, idx_d} == (len_q - 6'd1));
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StWaitInit;
            end
        endcase

        // Abort: no completion may be recorded once enable is low.
        if (!enable) begin
            state_d    = StWaitInit;
            rsp_data_d = rsp_data_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q    <= StWaitInit;
            op_q       <= OpTapReset;
            data_q     <= 32'd0;
            len_q      <= 6'd0;
            idx_q      <= 5'd0;
            cap_q      <= 32'd0;
            rsp_data_q <= 32'd0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            cap_q      <= cap_d;
            rsp_data_q <= rsp_data_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
        end
    end

`ifdef DBG_JTAG_VPI_TCK_COUNT_EN
    logic [31:0] tck_count_q, tck_count_d;

    assign tck_count = tck_count_q;

    // Count TCK rising edges (HI entries); wraps naturally at 2^32.
    always_comb begin
        tck_count_d = tck_count_q;
        if ((state_d == StHi) && (state_q != StHi)) begin
            tck_count_d = tck_count_q + 32'd1;
        end
    end

    // TCK rising-edge counter register.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            tck_count_q <= 32'd0;
        end else begin
            tck_count_q <= tck_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_dbg_jtag_vpi.sv
// Self-checking bench for dbg_jtag_vpi (TCK_DIV = 2). Latency is counted
// with the accepting cycle as cycle 0.
module tb_dbg_jtag_vpi;

    localparam int unsigned TckDiv = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        init_done;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        tck, tms, tdi, tdo;
    logic        tdo_loop;
    logic        tdo_fix;
`ifdef DBG_JTAG_VPI_TCK_COUNT_EN
    logic [31:0] tck_count;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pulses = 0;
    int          n_rsp    = 0;
    logic        tck_prev = 1'b0;
    logic        mon_tms[$];
    logic        mon_tdi[$];
    logic [31:0] exp_rsp[$];

    always #5 clk = ~clk;

    assign tdo = tdo_loop ? tdi : tdo_fix;

    dbg_jtag_vpi #(
        .TCK_DIV (TckDiv)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .enable    (enable),
        .init_done (init_done),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
`ifdef DBG_JTAG_VPI_TCK_COUNT_EN
        ,
        .tck_count (tck_count)
`endif
    );

    // Pin/response monitor, sampled on the falling system clock edge.
    always @(negedge clk) begin
        if (tck && !tck_prev) begin
            mon_tms.push_back(tms);
            mon_tdi.push_back(tdi);
            n_pulses++;
        end
        tck_prev = tck;
        if (rsp_valid) n_rsp++;
    end

    // Drive one command, wait for its response; reports latency and data.
    task automatic run_cmd(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data,
                           output int lat, output logic [31:0] rdata, output bit to);
        int n;
        bit got;
        @(negedge clk);
        mon_tms.delete();
        mon_tdi.delete();
        n_pulses  = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat   = 1;
        rdata = 32'd0;
        got   = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                rdata = rsp_data;
                got   = 1'b1;
                break;
            end
            lat++;
        end
        to = (n >= 200) || !got;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; init_done = 1'b1; cmd_valid = 1'b0;
        cmd_op = 2'd0; cmd_len = 5'd0; cmd_data = 32'd0; tdo_loop = 1'b1; tdo_fix = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cmd_ready, rsp_valid, tck, tms, tdi} !== 5'b00010) begin
            $display("FAIL reset_pins: got %b expected 00010", {cmd_ready, rsp_valid, tck, tms, tdi});
            n_errors++;
        end
        n_checks++;
        if (rsp_data !== 32'd0) begin
            $display("FAIL reset_rsp_data: got %h expected 00000000", rsp_data);
            n_errors++;
        end
`ifdef DBG_JTAG_VPI_TCK_COUNT_EN
        n_checks++;
        if (tck_count !== 32'd0) begin
            $display("FAIL reset_tck_count: got %0d expected 0", tck_count);
            n_errors++;
        end
`endif
        init_done = 1'b0;
    endtask

    task automatic test_init_gate();
        bit seen;
        seen = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            $display("FAIL init_gate_ready: got %b expected 0", seen);
            n_errors++;
        end
        init_done = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL init_ready_next: got %b expected 1", cmd_ready);
            n_errors++;
        end
        init_done = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL init_done_drop: got %b expected 1", cmd_ready);
            n_errors++;
        end
    endtask

    task automatic test_tap_reset();
        int lat; logic [31:0] rd, exp; bit to, bad;
        tdo_loop = 1'b0; tdo_fix = 1'b1;
        exp_rsp.push_back(32'h0000_001F);
        run_cmd(2'd0, 5'd7, 32'hFFFF_FFFF, lat, rd, to);
        exp = exp_rsp.pop_front();
        n_checks++;
        if (to || lat != 2 * TckDiv * 5 + 1) begin
            $display("FAIL tap_latency: got %0d (timeout %0d) expected %0d", lat, to, 2 * TckDiv * 5 + 1);
            n_errors++;
        end
        n_checks++;
        if (rd !== exp) begin
            $display("FAIL tap_rsp: got %h expected %h", rd, exp);
            n_errors++;
        end
        bad = (n_pulses != 5);
        foreach (mon_tms[i]) if (mon_tms[i] !== 1'b1 || mon_tdi[i] !== 1'b0) bad = 1'b1;
        n_checks++;
        if (bad) begin
            $display("FAIL tap_pins: pulses %0d expected 5 with tms=1 tdi=0", n_pulses);
            n_errors++;
        end
    endtask

    task automatic test_scan();
        int lat; logic [31:0] rd, exp, d; bit to, bad;
        d = 32'h0000_00A5;
        tdo_loop = 1'b1;
        exp_rsp.push_back(32'h0000_00A5);
        run_cmd(2'd2, 5'd8, d, lat, rd, to);
        exp = exp_rsp.pop_front();
        n_checks++;
        if (to || rd !== exp) begin
            $display("FAIL scan_rsp: got %h expected %h", rd, exp);
            n_errors++;
        end
        n_checks++;
        if (lat != 2 * TckDiv * 8 + 1) begin
            $display("FAIL scan_latency: got %0d expected %0d", lat, 2 * TckDiv * 8 + 1);
            n_errors++;
        end
        bad = (n_pulses != 8);
        foreach (mon_tdi[i]) if (mon_tdi[i] !== d[i] || mon_tms[i] !== 1'b0) bad = 1'b1;
        n_checks++;
        if (bad) begin
            $display("FAIL scan_pins: pulses %0d expected 8, tdi 1,0,1,0,0,1,0,1 tms 0", n_pulses);
            n_errors++;
        end
    endtask

    task automatic test_scan_exit();
        int lat; logic [31:0] rd, exp, d; bit to, bad;
        d = 32'hDEAD_BEEF;
        tdo_loop = 1'b0; tdo_fix = 1'b1;
        exp_rsp.push_back(32'hFFFF_FFFF);
        run_cmd(2'd3, 5'd0, d, lat, rd, to);
        exp = exp_rsp.pop_front();
        n_checks++;
        if (to || rd !== exp) begin
            $display("FAIL scan_exit_rsp: got %h expected %h", rd, exp);
            n_errors++;
        end
        n_checks++;
        if (lat != 129) begin
            $display("FAIL scan_exit_latency: got %0d expected 129", lat);
            n_errors++;
        end
        bad = (n_pulses != 32);
        foreach (mon_tms[i]) if (mon_tms[i] !== (i == 31) || mon_tdi[i] !== d[i]) bad = 1'b1;
        n_checks++;
        if (bad) begin
            $display("FAIL scan_exit_pins: pulses %0d expected 32, tms=1 only on bit 31", n_pulses);
            n_errors++;
        end
    endtask

    task automatic test_tms_seq();
        int lat; logic [31:0] rd, exp; logic [3:0] exp_tms; bit to, bad;
        exp_tms = 4'b0110;
        tdo_loop = 1'b0; tdo_fix = 1'b1;
        exp_rsp.push_back(32'h0000_000F);
        run_cmd(2'd1, 5'd4, 32'h0000_0006, lat, rd, to);
        exp = exp_rsp.pop_front();
        n_checks++;
        if (to || rd !== exp || lat != 2 * TckDiv * 4 + 1) begin
            $display("FAIL tms_seq_rsp: got %h lat %0d expected %h lat %0d", rd, lat, exp,
                     2 * TckDiv * 4 + 1);
            n_errors++;
        end
        bad = (n_pulses != 4);
        foreach (mon_tms[i]) if (mon_tms[i] !== exp_tms[i] || mon_tdi[i] !== 1'b0) bad = 1'b1;
        n_checks++;
        if (bad) begin
            $display("FAIL tms_seq_pins: pulses %0d expected 4, tms 0,1,1,0 tdi 0", n_pulses);
            n_errors++;
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd, exp, d, mask; bit to;
        int lens[4] = '{1, 3, 17, 31};
        tdo_loop = 1'b1;
        foreach (lens[j]) begin
            d    = $urandom;
            mask = (32'd1 << lens[j]) - 32'd1;
            exp_rsp.push_back(d & mask);
            run_cmd(2'd2, 5'(lens[j]), d, lat, rd, to);
            exp = exp_rsp.pop_front();
            n_checks++;
            if (to || rd !== exp || lat != 2 * TckDiv * lens[j] + 1) begin
                $display("FAIL b2b_len%0d: got %h lat %0d expected %h lat %0d", lens[j], rd, lat,
                         exp, 2 * TckDiv * lens[j] + 1);
                n_errors++;
            end
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (rsp_data !== exp) begin
            $display("FAIL rsp_hold: got %h expected %h", rsp_data, exp);
            n_errors++;
        end
    endtask

    task automatic test_abort();
        int base, n;
        rst_n = 1'b0; enable = 1'b1; init_done = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 5'd8; cmd_data = 32'h0000_00FF;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n_pulses = 0;
        base = n_rsp;
        n = 0;
        while (n_pulses < 4 && n < 100) begin
            @(negedge clk);
            #1 n++;
        end
        enable = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({tck, tms, tdi, cmd_ready} !== 4'b0100) begin
            $display("FAIL abort_pins: got %b expected 0100", {tck, tms, tdi, cmd_ready});
            n_errors++;
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (n_rsp != base || n_pulses != 4) begin
            $display("FAIL abort_quiet: got rsp %0d pulses %0d expected rsp %0d pulses 4",
                     n_rsp - base, n_pulses, 0);
            n_errors++;
        end
`ifdef DBG_JTAG_VPI_TCK_COUNT_EN
        n_checks++;
        if (tck_count !== 32'd4) begin
            $display("FAIL abort_tck_count: got %0d expected 4", tck_count);
            n_errors++;
        end
`endif
        #1 enable = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            $display("FAIL abort_wait_init: got %b expected 0", cmd_ready);
            n_errors++;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL abort_recover: got %b expected 1", cmd_ready);
            n_errors++;
        end
    endtask

    task automatic test_reset_mid();
        int base, n;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 5'd16; cmd_data = 32'h0000_1234;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n_pulses = 0;
        base = n_rsp;
        n = 0;
        while (n_pulses < 2 && n < 100) begin
            @(negedge clk);
            #1 n++;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cmd_ready, tck, tms, tdi} !== 4'b0010 || rsp_data !== 32'd0) begin
            $display("FAIL reset_mid_state: got %b %h expected 0010 00000000",
                     {cmd_ready, tck, tms, tdi}, rsp_data);
            n_errors++;
        end
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        n_checks++;
        if (n_rsp != base) begin
            $display("FAIL reset_mid_rsp: got %0d responses expected 0", n_rsp - base);
            n_errors++;
        end
    endtask

    initial begin
        test_reset();
        test_init_gate();
        test_tap_reset();
        test_scan();
        test_scan_exit();
        test_tms_seq();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
